// File: rtl/avst_pkt_rx_pkg.sv
// Shared types, LFSR constants and the 32-bit lane XOR fold for avst_pkt_rx_checker.
// The fold takes a zero-extended beat, so any DATA_WIDTH up to FOLD_MAX_W shares one function.
package avst_pkt_rx_pkg;

    typedef enum logic [1:0] {
        IDLE,
        IN_PKT,
        DRAIN
    } rx_state_t;

    typedef enum logic [1:0] {
        ERR_NONE       = 2'd0,
        ERR_NO_SOF     = 2'd1,
        ERR_SOF_IN_PKT = 2'd2,
        ERR_OVERSIZE   = 2'd3
    } rx_err_t;

    localparam logic [15:0] LFSR_SEED  = 16'hACE1;
    // Taps 16, 14, 13 and 11 expressed as bit positions 15, 13, 12 and 10.
    localparam logic [15:0] LFSR_TAPS  = 16'hB400;
    localparam int          FOLD_MAX_W = 2048;

    function automatic logic [31:0] lane_fold(input logic [FOLD_MAX_W-1:0] data);
        logic [31:0] acc;
        acc = '0;
        for (int i = 0; i < FOLD_MAX_W / 32; i++) begin
            acc = acc ^ data[i*32 +: 32];
        end
        return acc;
    endfunction

endpackage

// File: rtl/avalonST_pkt_iface.sv
// Packet stream bundle: valid/ready handshake with SOF/EOF framing flags.
interface avalonST_pkt_iface #(
    parameter int DATA_WIDTH = 512
);
    logic                  if_vld;
    logic                  if_rdy;
    logic                  if_sof;
    logic                  if_eof;
    logic [DATA_WIDTH-1:0] if_data;

    modport source (output if_vld, output if_data, output if_sof, output if_eof, input if_rdy);
    modport sink   (input if_vld, input if_data, input if_sof, input if_eof, output if_rdy);
endinterface

// File: rtl/avst_pkt_rx_lfsr.sv
// 16-bit Fibonacci LFSR used to throttle ready; only built with AVST_PKT_RX_BACKPRESSURE_EN.
`ifdef AVST_PKT_RX_BACKPRESSURE_EN
module avst_pkt_rx_lfsr
    import avst_pkt_rx_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        adv,
    output logic [15:0] state
);

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (adv) begin
            lfsr_d = {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign state = lfsr_q;

endmodule
`endif

// File: rtl/avst_pkt_rx_checker.sv
// End-of-chain packet checker: framing/length checks, per-packet report, wrap-around counters.
// Optional macro AVST_PKT_RX_BACKPRESSURE_EN throttles if_rdy with a 16-bit LFSR.
module avst_pkt_rx_checker
    import avst_pkt_rx_pkg::*;
#(
    parameter int  DATA_WIDTH = 512,
    parameter int  MAX_BEATS  = 256,
    parameter int  CNT_W      = 32,
    localparam int LEN_W      = $clog2(MAX_BEATS) + 1
) (
    input  logic              clk,
    input  logic              rst,
    avalonST_pkt_iface.sink   s_if,
    input  logic              en,
    input  logic              cnt_clr,
    output logic              rpt_vld,
    output logic [LEN_W-1:0]  rpt_len,
    output logic [31:0]       rpt_csum,
    output logic [1:0]        rpt_err,
    output logic [CNT_W-1:0]  pkt_cnt,
    output logic [CNT_W-1:0]  err_cnt
);

    rx_state_t          state_q, state_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [31:0]        csum_q, csum_d;
    logic               rpt_vld_q, rpt_vld_d;
    logic [LEN_W-1:0]   rpt_len_q, rpt_len_d;
    logic [31:0]        rpt_csum_q, rpt_csum_d;
    rx_err_t            rpt_err_q, rpt_err_d;
    logic [CNT_W-1:0]   pkt_cnt_q, pkt_cnt_d;
    logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;
    logic               rdy_q, rdy_d;

    logic [DATA_WIDTH-1:0] beat_data;
    logic [31:0]           beat_csum;
    logic [31:0]           csum_upd;
    logic [LEN_W-1:0]      len_inc;
    logic                  beat_acc;

    assign beat_data = s_if.if_data;
    assign beat_csum = lane_fold(FOLD_MAX_W'(beat_data));
    assign csum_upd  = csum_q ^ beat_csum;
    assign len_inc   = len_q + LEN_W'(1);
    assign beat_acc  = s_if.if_vld & rdy_q;

`ifdef AVST_PKT_RX_BACKPRESSURE_EN
    logic [15:0] lfsr_state;

    avst_pkt_rx_lfsr u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .adv   (1'b1),
        .state (lfsr_state)
    );

    assign rdy_d = en & (lfsr_state[1:0] != 2'b00);
`else
    assign rdy_d = en;
`endif

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        csum_d     = csum_q;
        rpt_vld_d  = 1'b0;
        rpt_len_d  = rpt_len_q;
        rpt_csum_d = rpt_csum_q;
        rpt_err_d  = rpt_err_q;

        if (beat_acc) begin
            unique case (state_q)
                IDLE: begin
                    if (!s_if.if_sof) begin
                        rpt_vld_d  = 1'b1;
                        rpt_len_d  = '0;
                        rpt_csum_d = '0;
                        rpt_err_d  = ERR_NO_SOF;
                    end else if (s_if.if_eof) begin
                        rpt_vld_d  = 1'b1;
                        rpt_len_d  = LEN_W'(1);
                        rpt_csum_d = beat_csum;
                        rpt_err_d  = ERR_NONE;
                    end else begin
                        state_d = IN_PKT;
                        len_d   = LEN_W'(1);
                        csum_d  = beat_csum;
                    end
                end
                IN_PKT: begin
                    // A stray SOF closes the open packet with what it had; the SOF beat is dropped.
                    if (s_if.if_sof) begin
                        state_d    = IDLE;
                        rpt_vld_d  = 1'b1;
                        rpt_len_d  = len_q;
                        rpt_csum_d = csum_q;
                        rpt_err_d  = ERR_SOF_IN_PKT;
                    end else if (s_if.if_eof) begin
                        state_d    = IDLE;
                        rpt_vld_d  = 1'b1;
                        rpt_len_d  = len_inc;
                        rpt_csum_d = csum_upd;
                        rpt_err_d  = ERR_NONE;
                    end else if (len_inc == LEN_W'(MAX_BEATS)) begin
                        state_d    = DRAIN;
                        rpt_vld_d  = 1'b1;
                        rpt_len_d  = LEN_W'(MAX_BEATS);
                        rpt_csum_d = csum_upd;
                        rpt_err_d  = ERR_OVERSIZE;
                    end else begin
                        len_d  = len_inc;
                        csum_d = csum_upd;
                    end
                end
                DRAIN: begin
                    if (s_if.if_eof) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_comb begin
        pkt_cnt_d = pkt_cnt_q;
        err_cnt_d = err_cnt_q;
        if (cnt_clr) begin
            pkt_cnt_d = '0;
            err_cnt_d = '0;
        end else if (rpt_vld_d) begin
            if (rpt_err_d == ERR_NONE) begin
                pkt_cnt_d = pkt_cnt_q + CNT_W'(1);
            end else begin
                err_cnt_d = err_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            len_q      <= '0;
            csum_q     <= '0;
            rpt_vld_q  <= 1'b0;
            rpt_len_q  <= '0;
            rpt_csum_q <= '0;
            rpt_err_q  <= ERR_NONE;
            pkt_cnt_q  <= '0;
            err_cnt_q  <= '0;
            rdy_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            csum_q     <= csum_d;
            rpt_vld_q  <= rpt_vld_d;
            rpt_len_q  <= rpt_len_d;
            rpt_csum_q <= rpt_csum_d;
            rpt_err_q  <= rpt_err_d;
            pkt_cnt_q  <= pkt_cnt_d;
            err_cnt_q  <= err_cnt_d;
            rdy_q      <= rdy_d;
        end
    end

    assign s_if.if_rdy = rdy_q;
    assign rpt_vld     = rpt_vld_q;
    assign rpt_len     = rpt_len_q;
    assign rpt_csum    = rpt_csum_q;
    assign rpt_err     = rpt_err_q;
    assign pkt_cnt     = pkt_cnt_q;
    assign err_cnt     = err_cnt_q;

endmodule

// File: tb/tb_avst_pkt_rx_checker.sv
// Self-checking bench for avst_pkt_rx_checker: directed scenarios plus randomized traffic
// compared against a packet-level reference model; AVST_PKT_RX_BACKPRESSURE_EN adds the LFSR run.
module tb_avst_pkt_rx_checker;

    localparam int DW        = 64;
    localparam int LANES     = DW / 32;
    localparam int MAX_BEATS = 8;
    localparam int CNT_W     = 4;
    localparam int LEN_W     = $clog2(MAX_BEATS) + 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             en;
    logic             cnt_clr;
    logic             rpt_vld;
    logic [LEN_W-1:0] rpt_len;
    logic [31:0]      rpt_csum;
    logic [1:0]       rpt_err;
    logic [CNT_W-1:0] pkt_cnt;
    logic [CNT_W-1:0] err_cnt;

    avalonST_pkt_iface #(.DATA_WIDTH(DW)) s_if ();

    avst_pkt_rx_checker #(
        .DATA_WIDTH (DW),
        .MAX_BEATS  (MAX_BEATS),
        .CNT_W      (CNT_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .s_if     (s_if),
        .en       (en),
        .cnt_clr  (cnt_clr),
        .rpt_vld  (rpt_vld),
        .rpt_len  (rpt_len),
        .rpt_csum (rpt_csum),
        .rpt_err  (rpt_err),
        .pkt_cnt  (pkt_cnt),
        .err_cnt  (err_cnt)
    );

    always #5 clk = ~clk;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    // Reference model: packet bookkeeping plus the expected report and counters.
    bit          m_rdy;
    bit          m_open;
    bit          m_drop;
    int          m_len;
    logic [31:0] m_csum;
    logic [15:0] m_lfsr;
    bit          e_vld;
    int          e_len;
    logic [31:0] e_csum;
    int          e_err;
    int          e_pkt;
    int          e_errc;

    function automatic logic [31:0] fold(input logic [DW-1:0] d);
        logic [31:0] x;
        x = '0;
        for (int i = 0; i < LANES; i++) x = x ^ d[32*i +: 32];
        return x;
    endfunction

    task automatic model_reset();
        m_rdy = 0; m_open = 0; m_drop = 0; m_len = 0; m_csum = '0; m_lfsr = 16'hACE1;
        e_vld = 0; e_len = 0; e_csum = '0; e_err = 0; e_pkt = 0; e_errc = 0;
    endtask

    task automatic model_step();
        bit          fire;
        int          len;
        logic [31:0] cs;
        int          err;
        logic [31:0] f;
        fire = 0; len = 0; cs = '0; err = 0;
        f = fold(s_if.if_data);
        if (s_if.if_vld && m_rdy) begin
            if (m_drop) begin
                if (s_if.if_eof) m_drop = 0;
            end else if (!m_open) begin
                if (!s_if.if_sof) begin
                    fire = 1; len = 0; cs = '0; err = 1;
                end else if (s_if.if_eof) begin
                    fire = 1; len = 1; cs = f; err = 0;
                end else begin
                    m_open = 1; m_len = 1; m_csum = f;
                end
            end else if (s_if.if_sof) begin
                fire = 1; len = m_len; cs = m_csum; err = 2; m_open = 0;
            end else begin
                m_len = m_len + 1;
                m_csum = m_csum ^ f;
                if (s_if.if_eof) begin
                    fire = 1; len = m_len; cs = m_csum; err = 0; m_open = 0;
                end else if (m_len == MAX_BEATS) begin
                    fire = 1; len = MAX_BEATS; cs = m_csum; err = 3; m_open = 0; m_drop = 1;
                end
            end
        end
        e_vld = fire;
        if (fire) begin
            e_len = len; e_csum = cs; e_err = err;
        end
        if (cnt_clr) begin
            e_pkt = 0; e_errc = 0;
        end else if (fire) begin
            if (err == 0) e_pkt = (e_pkt + 1) % (1 << CNT_W);
            else          e_errc = (e_errc + 1) % (1 << CNT_W);
        end
`ifdef AVST_PKT_RX_BACKPRESSURE_EN
        m_rdy  = en && (m_lfsr[1:0] != 2'b00);
        m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
`else
        m_rdy = en;
`endif
    endtask

    task automatic cycle(input bit v, input bit s, input bit e, input logic [DW-1:0] d);
        s_if.if_vld  = v;
        s_if.if_sof  = s;
        s_if.if_eof  = e;
        s_if.if_data = d;
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cnt_clr = 1'b0;
        s_if.if_vld = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        en = 1'b1;
        #1;
        chk_cnt++; if (s_if.if_rdy !== 1'b0) $display("[TB] FAIL reset_rdy: got %b expected 0", s_if.if_rdy); else pass_cnt++;
        chk_cnt++; if (rpt_vld !== 1'b0) $display("[TB] FAIL reset_vld: got %b expected 0", rpt_vld); else pass_cnt++;
        chk_cnt++; if (rpt_len !== '0) $display("[TB] FAIL reset_len: got %0d expected 0", rpt_len); else pass_cnt++;
        chk_cnt++; if (rpt_csum !== '0) $display("[TB] FAIL reset_csum: got %h expected 0", rpt_csum); else pass_cnt++;
        chk_cnt++; if (rpt_err !== 2'd0) $display("[TB] FAIL reset_err: got %0d expected 0", rpt_err); else pass_cnt++;
        chk_cnt++; if (pkt_cnt !== '0) $display("[TB] FAIL reset_pkt_cnt: got %0d expected 0", pkt_cnt); else pass_cnt++;
        chk_cnt++; if (err_cnt !== '0) $display("[TB] FAIL reset_err_cnt: got %0d expected 0", err_cnt); else pass_cnt++;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_four_beat();
        do_reset();
        en = 1'b1;
        cycle(0, 0, 0, '0);
        chk_cnt++; if (s_if.if_rdy !== 1'b1) $display("[TB] FAIL four_rdy: got %b expected 1", s_if.if_rdy); else pass_cnt++;
        for (int i = 0; i < 4; i++) begin
            cycle(1, i == 0, i == 3, DW'(64'd1 << i));
            if (i < 3) begin
                chk_cnt++; if (rpt_vld !== 1'b0) $display("[TB] FAIL four_early_vld beat %0d: got %b expected 0", i, rpt_vld); else pass_cnt++;
            end
        end
        chk_cnt++; if (rpt_vld !== 1'b1) $display("[TB] FAIL four_vld: got %b expected 1", rpt_vld); else pass_cnt++;
        chk_cnt++; if (rpt_len !== LEN_W'(4)) $display("[TB] FAIL four_len: got %0d expected 4", rpt_len); else pass_cnt++;
        chk_cnt++; if (rpt_csum !== 32'hF) $display("[TB] FAIL four_csum: got %h expected f", rpt_csum); else pass_cnt++;
        chk_cnt++; if (rpt_err !== 2'd0) $display("[TB] FAIL four_err: got %0d expected 0", rpt_err); else pass_cnt++;
        chk_cnt++; if (pkt_cnt !== CNT_W'(1)) $display("[TB] FAIL four_pkt_cnt: got %0d expected 1", pkt_cnt); else pass_cnt++;
        cycle(0, 0, 0, '0);
        chk_cnt++; if (rpt_vld !== 1'b0) $display("[TB] FAIL four_strobe: got %b expected 0", rpt_vld); else pass_cnt++;
        chk_cnt++; if (rpt_len !== LEN_W'(4)) $display("[TB] FAIL four_hold_len: got %0d expected 4", rpt_len); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] d;
        do_reset();
        en = 1'b1;
        cycle(0, 0, 0, '0);
        for (int i = 0; i < 10; i++) begin
            d = {$urandom, $urandom};
            cycle(1, 1, 1, d);
            chk_cnt++; if (rpt_vld !== 1'b1) $display("[TB] FAIL b2b_vld %0d: got %b expected 1", i, rpt_vld); else pass_cnt++;
            chk_cnt++; if (rpt_len !== LEN_W'(1)) $display("[TB] FAIL b2b_len %0d: got %0d expected 1", i, rpt_len); else pass_cnt++;
            chk_cnt++; if (rpt_csum !== fold(d)) $display("[TB] FAIL b2b_csum %0d: got %h expected %h", i, rpt_csum, fold(d)); else pass_cnt++;
        end
        chk_cnt++; if (pkt_cnt !== CNT_W'(10)) $display("[TB] FAIL b2b_pkt_cnt: got %0d expected 10", pkt_cnt); else pass_cnt++;
    endtask

    task automatic test_framing_errors();
        logic [DW-1:0] d;
        do_reset();
        en = 1'b1;
        cycle(0, 0, 0, '0);
        cycle(1, 0, 0, {$urandom, $urandom});
        chk_cnt++; if (rpt_vld !== 1'b1 || rpt_err !== 2'd1) $display("[TB] FAIL nosof_code: got vld %b err %0d expected vld 1 err 1", rpt_vld, rpt_err); else pass_cnt++;
        chk_cnt++; if (rpt_len !== '0 || rpt_csum !== '0) $display("[TB] FAIL nosof_len: got len %0d csum %h expected 0 0", rpt_len, rpt_csum); else pass_cnt++;
        d = {$urandom, $urandom};
        cycle(1, 1, 0, d);
        chk_cnt++; if (rpt_vld !== 1'b0) $display("[TB] FAIL sofpkt_open_vld: got %b expected 0", rpt_vld); else pass_cnt++;
        cycle(1, 1, 0, {$urandom, $urandom});
        chk_cnt++; if (rpt_vld !== 1'b1 || rpt_err !== 2'd2) $display("[TB] FAIL sofpkt_code: got vld %b err %0d expected vld 1 err 2", rpt_vld, rpt_err); else pass_cnt++;
        chk_cnt++; if (rpt_len !== LEN_W'(1)) $display("[TB] FAIL sofpkt_len: got %0d expected 1", rpt_len); else pass_cnt++;
        chk_cnt++; if (rpt_csum !== fold(d)) $display("[TB] FAIL sofpkt_csum: got %h expected %h", rpt_csum, fold(d)); else pass_cnt++;
        chk_cnt++; if (err_cnt !== CNT_W'(2) || pkt_cnt !== '0) $display("[TB] FAIL framing_cnts: got err %0d pkt %0d expected 2 0", err_cnt, pkt_cnt); else pass_cnt++;
    endtask

    task automatic test_oversize();
        do_reset();
        en = 1'b1;
        cycle(0, 0, 0, '0);
        for (int i = 0; i < 12; i++) begin
            cycle(1, i == 0, i == 11, DW'(i + 1));
            chk_cnt++; if (rpt_vld !== (i == 7)) $display("[TB] FAIL over_vld beat %0d: got %b expected %b", i, rpt_vld, i == 7); else pass_cnt++;
            if (i == 7) begin
                chk_cnt++; if (rpt_len !== LEN_W'(8) || rpt_err !== 2'd3) $display("[TB] FAIL over_report: got len %0d err %0d expected 8 3", rpt_len, rpt_err); else pass_cnt++;
            end
        end
        cycle(1, 1, 0, DW'(32'h100));
        cycle(1, 0, 0, DW'(32'h200));
        cycle(1, 0, 1, DW'(32'h400));
        chk_cnt++; if (rpt_vld !== 1'b1 || rpt_len !== LEN_W'(3) || rpt_err !== 2'd0) $display("[TB] FAIL over_next: got vld %b len %0d err %0d expected 1 3 0", rpt_vld, rpt_len, rpt_err); else pass_cnt++;
        chk_cnt++; if (rpt_csum !== 32'h700) $display("[TB] FAIL over_next_csum: got %h expected 700", rpt_csum); else pass_cnt++;
        chk_cnt++; if (pkt_cnt !== CNT_W'(1) || err_cnt !== CNT_W'(1)) $display("[TB] FAIL over_cnts: got pkt %0d err %0d expected 1 1", pkt_cnt, err_cnt); else pass_cnt++;
        for (int i = 0; i < MAX_BEATS; i++) cycle(1, i == 0, i == MAX_BEATS - 1, DW'(64'd1 << i));
        chk_cnt++; if (rpt_vld !== 1'b1 || rpt_len !== LEN_W'(8) || rpt_err !== 2'd0) $display("[TB] FAIL exact_max: got vld %b len %0d err %0d expected 1 8 0", rpt_vld, rpt_len, rpt_err); else pass_cnt++;
        chk_cnt++; if (rpt_csum !== 32'hFF) $display("[TB] FAIL exact_max_csum: got %h expected ff", rpt_csum); else pass_cnt++;
    endtask

    task automatic test_reset_mid_packet();
        int pulses;
        int last_len;
        do_reset();
        en = 1'b1;
        cycle(0, 0, 0, '0);
        cycle(1, 1, 1, DW'(5));
        cycle(1, 1, 0, DW'(6));
        cycle(1, 0, 0, DW'(7));
        rst = 1'b1;
        #2;
        chk_cnt++; if (pkt_cnt !== '0 || err_cnt !== '0) $display("[TB] FAIL midrst_cnts: got pkt %0d err %0d expected 0 0", pkt_cnt, err_cnt); else pass_cnt++;
        chk_cnt++; if (rpt_vld !== 1'b0 || s_if.if_rdy !== 1'b0) $display("[TB] FAIL midrst_outs: got vld %b rdy %b expected 0 0", rpt_vld, s_if.if_rdy); else pass_cnt++;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        cycle(0, 0, 0, '0);
        pulses = 0;
        last_len = -1;
        for (int i = 0; i < 5; i++) begin
            if (i < 3) cycle(1, i == 0, i == 2, DW'(i + 9));
            else       cycle(0, 0, 0, '0);
            if (rpt_vld === 1'b1) begin
                pulses++;
                last_len = int'(rpt_len);
            end
        end
        chk_cnt++; if (pulses != 1) $display("[TB] FAIL midrst_pulses: got %0d expected 1", pulses); else pass_cnt++;
        chk_cnt++; if (last_len != 3) $display("[TB] FAIL midrst_len: got %0d expected 3", last_len); else pass_cnt++;
    endtask

    task automatic test_en_hold();
        do_reset();
        en = 1'b1;
        cycle(0, 0, 0, '0);
        cycle(1, 1, 0, DW'(32'h10));
        en = 1'b0;
        cycle(1, 0, 0, DW'(32'h20));
        for (int i = 0; i < 3; i++) begin
            cycle(1, 1, 1, '1);
            chk_cnt++; if (s_if.if_rdy !== 1'b0 || rpt_vld !== 1'b0) $display("[TB] FAIL en_hold %0d: got rdy %b vld %b expected 0 0", i, s_if.if_rdy, rpt_vld); else pass_cnt++;
        end
        en = 1'b1;
        cycle(0, 0, 0, '0);
        cycle(1, 0, 0, DW'(32'h40));
        cycle(1, 0, 1, DW'(32'h80));
        chk_cnt++; if (rpt_vld !== 1'b1 || rpt_len !== LEN_W'(4) || rpt_err !== 2'd0) $display("[TB] FAIL en_resume: got vld %b len %0d err %0d expected 1 4 0", rpt_vld, rpt_len, rpt_err); else pass_cnt++;
        chk_cnt++; if (rpt_csum !== 32'hF0) $display("[TB] FAIL en_resume_csum: got %h expected f0", rpt_csum); else pass_cnt++;
    endtask

    task automatic test_cnt_clr();
        do_reset();
        en = 1'b1;
        cycle(0, 0, 0, '0);
        cycle(1, 1, 1, DW'(1));
        cycle(1, 0, 0, DW'(2));
        cnt_clr = 1'b1;
        cycle(1, 1, 1, DW'(3));
        chk_cnt++; if (rpt_vld !== 1'b1 || pkt_cnt !== '0 || err_cnt !== '0) $display("[TB] FAIL clr_wins: got vld %b pkt %0d err %0d expected 1 0 0", rpt_vld, pkt_cnt, err_cnt); else pass_cnt++;
        cnt_clr = 1'b0;
        cycle(1, 1, 1, DW'(4));
        chk_cnt++; if (pkt_cnt !== CNT_W'(1)) $display("[TB] FAIL clr_after: got %0d expected 1", pkt_cnt); else pass_cnt++;
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 2000; c++) begin
            en      = ($urandom_range(0, 9) != 0);
            cnt_clr = ($urandom_range(0, 49) == 0);
            cycle($urandom_range(0, 4) != 0, $urandom_range(0, 4) == 0, $urandom_range(0, 3) == 0, {$urandom, $urandom});
            chk_cnt++; if (s_if.if_rdy !== m_rdy) $display("[TB] FAIL rand_rdy cyc %0d: got %b expected %b", c, s_if.if_rdy, m_rdy); else pass_cnt++;
            chk_cnt++; if (rpt_vld !== e_vld) $display("[TB] FAIL rand_vld cyc %0d: got %b expected %b", c, rpt_vld, e_vld); else pass_cnt++;
            chk_cnt++; if (rpt_len !== LEN_W'(e_len)) $display("[TB] FAIL rand_len cyc %0d: got %0d expected %0d", c, rpt_len, e_len); else pass_cnt++;
            chk_cnt++; if (rpt_csum !== e_csum) $display("[TB] FAIL rand_csum cyc %0d: got %h expected %h", c, rpt_csum, e_csum); else pass_cnt++;
            chk_cnt++; if (rpt_err !== 2'(e_err)) $display("[TB] FAIL rand_err cyc %0d: got %0d expected %0d", c, rpt_err, e_err); else pass_cnt++;
            chk_cnt++; if (pkt_cnt !== CNT_W'(e_pkt)) $display("[TB] FAIL rand_pkt_cnt cyc %0d: got %0d expected %0d", c, pkt_cnt, e_pkt); else pass_cnt++;
            chk_cnt++; if (err_cnt !== CNT_W'(e_errc)) $display("[TB] FAIL rand_err_cnt cyc %0d: got %0d expected %0d", c, err_cnt, e_errc); else pass_cnt++;
        end
        cnt_clr = 1'b0;
    endtask

`ifdef AVST_PKT_RX_BACKPRESSURE_EN
    task automatic test_backpressure();
        do_reset();
        en = 1'b1;
        for (int c = 0; c < 1000; c++) begin
            cycle(1, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, {$urandom, $urandom});
            chk_cnt++; if (s_if.if_rdy !== m_rdy) $display("[TB] FAIL bp_rdy cyc %0d: got %b expected %b", c, s_if.if_rdy, m_rdy); else pass_cnt++;
            chk_cnt++; if (rpt_vld !== e_vld) $display("[TB] FAIL bp_vld cyc %0d: got %b expected %b", c, rpt_vld, e_vld); else pass_cnt++;
            if (e_vld) begin
                chk_cnt++; if (rpt_len !== LEN_W'(e_len) || rpt_err !== 2'(e_err) || rpt_csum !== e_csum) $display("[TB] FAIL bp_report cyc %0d: got len %0d err %0d csum %h expected %0d %0d %h", c, rpt_len, rpt_err, rpt_csum, e_len, e_err, e_csum); else pass_cnt++;
            end
        end
        chk_cnt++; if (pkt_cnt !== CNT_W'(e_pkt) || err_cnt !== CNT_W'(e_errc)) $display("[TB] FAIL bp_cnts: got pkt %0d err %0d expected %0d %0d", pkt_cnt, err_cnt, e_pkt, e_errc); else pass_cnt++;
    endtask
`endif

    initial begin
        rst          = 1'b1;
        en           = 1'b0;
        cnt_clr      = 1'b0;
        s_if.if_vld  = 1'b0;
        s_if.if_sof  = 1'b0;
        s_if.if_eof  = 1'b0;
        s_if.if_data = '0;
        model_reset();
        test_reset();
`ifndef AVST_PKT_RX_BACKPRESSURE_EN
        test_four_beat();
        test_back_to_back();
        test_framing_errors();
        test_oversize();
        test_reset_mid_packet();
        test_en_hold();
        test_cnt_clr();
`endif
        test_random();
`ifdef AVST_PKT_RX_BACKPRESSURE_EN
        test_backpressure();
`endif
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
